// File: rtl/set_assoc_dcache.sv
// N-way set-associative write-through, no-write-allocate data cache with true-LRU replacement
// and whole-line refill over a valid/ready memory port; one request in flight at a time.
module set_assoc_dcache #(
    parameter int unsigned ADDR_WID       = 32,
    parameter int unsigned WORD_WID       = 64,
    parameter int unsigned NUM_SETS       = 64,
    parameter int unsigned NUM_WAYS       = 4,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  invalidate_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WID-1:0]   req_addr_i,
    input  logic [WORD_WID-1:0]   req_wdata_i,
    input  logic [WORD_WID/8-1:0] req_be_i,
    output logic                  rsp_valid_o,
    output logic [WORD_WID-1:0]   rsp_rdata_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_req_we_o,
    output logic [ADDR_WID-1:0]   mem_req_addr_o,
    output logic [WORD_WID-1:0]   mem_req_wdata_o,
    output logic [WORD_WID/8-1:0] mem_req_be_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [WORD_WID-1:0]   mem_rsp_data_i
);
    localparam int unsigned BYTES = WORD_WID / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned SET_W = $clog2(NUM_SETS);
    localparam int unsigned WAY_W = $clog2(NUM_WAYS);
    localparam int unsigned TAG_W = ADDR_WID - OFF_W - IDX_W - SET_W;
    localparam logic [ADDR_WID-1:0] WORD_MASK = ~ADDR_WID'(BYTES - 1);
    localparam logic [ADDR_WID-1:0] LINE_MASK = ~ADDR_WID'(BYTES * WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {StIdle, StLookup, StWriteMem, StRefillReq, StRefill} state_e;

    state_e               state_q;
    logic                 req_we_q;
    logic [ADDR_WID-1:0]  req_addr_q;
    logic [WORD_WID-1:0]  req_wdata_q;
    logic [BYTES-1:0]     req_be_q;
    logic [WAY_W-1:0]     victim_q;
    logic [IDX_W-1:0]     beat_q;

    logic                 valid_q [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]     age_q   [NUM_SETS][NUM_WAYS];
    logic [WORD_WID-1:0]  data_q  [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];

    logic [IDX_W-1:0]     req_widx;
    logic [SET_W-1:0]     req_set;
    logic [TAG_W-1:0]     req_tag;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     victim;
    logic [WAY_W-1:0]     lru_way;
    logic [WAY_W-1:0]     age_upd [NUM_WAYS];
    logic                 last_beat;

    assign req_widx    = req_addr_q[OFF_W +: IDX_W];
    assign req_set     = req_addr_q[OFF_W + IDX_W +: SET_W];
    assign req_tag     = req_addr_q[ADDR_WID-1 -: TAG_W];
    assign req_ready_o = (state_q == StIdle) && !invalidate_i;
    assign last_beat   = (beat_q == IDX_W'(WORDS_PER_LINE - 1));

    // Victim: lowest-index invalid way wins, otherwise the oldest way.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (age_q[req_set][w] == WAY_W'(NUM_WAYS - 1)) begin
                victim = WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_set][w]) begin
                victim = WAY_W'(w);
            end
        end
    end

    // Ages younger than the touched way shift up by one; the touched way becomes youngest.
    always_comb begin
        lru_way = (state_q == StRefill) ? victim_q : hit_way;
        for (int w = 0; w < NUM_WAYS; w++) begin
            age_upd[w] = age_q[req_set][w];
            if (WAY_W'(w) == lru_way) begin
                age_upd[w] = '0;
            end else if (age_q[req_set][w] < age_q[req_set][lru_way]) begin
                age_upd[w] = age_q[req_set][w] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            req_we_q        <= 1'b0;
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            req_be_q        <= '0;
            victim_q        <= '0;
            beat_q          <= '0;
            rsp_valid_o     <= 1'b0;
            rsp_rdata_o     <= '0;
            mem_req_valid_o <= 1'b0;
            mem_req_we_o    <= 1'b0;
            mem_req_addr_o  <= '0;
            mem_req_wdata_o <= '0;
            mem_req_be_o    <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            rsp_valid_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (invalidate_i) begin
                        for (int s = 0; s < NUM_SETS; s++) begin
                            for (int w = 0; w < NUM_WAYS; w++) begin
                                valid_q[s][w] <= 1'b0;
                            end
                        end
                    end else if (req_valid_i) begin
                        req_we_q    <= req_we_i;
                        req_addr_q  <= req_addr_i & WORD_MASK;
                        req_wdata_q <= req_wdata_i;
                        req_be_q    <= req_be_i;
                        state_q     <= StLookup;
                    end
                end
                StLookup: begin
                    if (req_we_q) begin
                        if (hit) begin
                            for (int w = 0; w < NUM_WAYS; w++) age_q[req_set][w] <= age_upd[w];
                        end
                        mem_req_valid_o <= 1'b1;
                        mem_req_we_o    <= 1'b1;
                        mem_req_addr_o  <= req_addr_q;
                        mem_req_wdata_o <= req_wdata_q;
                        mem_req_be_o    <= req_be_q;
                        state_q         <= StWriteMem;
                    end else if (hit) begin
                        for (int w = 0; w < NUM_WAYS; w++) age_q[req_set][w] <= age_upd[w];
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= data_q[req_set][hit_way][req_widx];
                        state_q     <= StIdle;
                    end else begin
                        victim_q        <= victim;
                        beat_q          <= '0;
                        mem_req_valid_o <= 1'b1;
                        mem_req_we_o    <= 1'b0;
                        mem_req_addr_o  <= req_addr_q & LINE_MASK;
                        mem_req_wdata_o <= '0;
                        mem_req_be_o    <= '0;
                        state_q         <= StRefillReq;
                    end
                end
                StWriteMem: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        rsp_valid_o     <= 1'b1;
                        rsp_rdata_o     <= '0;
                        state_q         <= StIdle;
                    end
                end
                StRefillReq: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        state_q         <= StRefill;
                    end
                end
                StRefill: begin
                    if (mem_rsp_valid_i) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == '0) valid_q[req_set][victim_q] <= 1'b0;
                        if (last_beat) begin
                            valid_q[req_set][victim_q] <= 1'b1;
                            for (int w = 0; w < NUM_WAYS; w++) age_q[req_set][w] <= age_upd[w];
                            rsp_valid_o <= 1'b1;
                            // The requested word may be arriving on this very beat.
                            rsp_rdata_o <= (req_widx == beat_q) ? mem_rsp_data_i
                                                                : data_q[req_set][victim_q][req_widx];
                            state_q     <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Line storage carries no reset; validity is tracked by valid_q alone.
    always_ff @(posedge clk_i) begin
        if (state_q == StLookup && req_we_q && hit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_be_q[b]) data_q[req_set][hit_way][req_widx][8*b +: 8] <= req_wdata_q[8*b +: 8];
            end
        end
        if (state_q == StRefill && mem_rsp_valid_i) begin
            data_q[req_set][victim_q][beat_q] <= mem_rsp_data_i;
            if (last_beat) tag_q[req_set][victim_q] <= req_tag;
        end
    end
endmodule
